rv32im_br_unit: RTL and testbench
=================================

Name: rv32im_br_unit

Overview:
- Parametrised successor to the combinational branch-offset block.
- Resolves conditional branches, JAL and JALR in EX using its own rs1/rs2 comparator, so there is no alu_zero dependency and signed/unsigned compares are handled correctly.
- Holds a BHT of 2-bit saturating counters that fetch uses to predict direction.
- Issues a registered one-cycle redirect on mispredict and keeps saturating branch/mispredict statistics.

Parameters:
- API_ADDR_WIDTH, 32, PC/target width.
- API_DATA_WIDTH, 32, operand and immediate width.
- BHT_ENTRIES, 64, number of counters; power of two, >=2.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- fetch_pc_i  in  API_ADDR_WIDTH  PC being fetched
- fetch_pred_taken_o  out  1  BHT prediction for fetch_pc_i; combinational
- res_valid_i  in  1  control-flow instruction present in EX
- res_pc_i  in  API_ADDR_WIDTH  its PC
- res_pred_taken_i  in  1  prediction carried down the pipe with it
- res_conditional_i  in  1  conditional branch
- res_jal_i  in  1  JAL
- res_jalr_i  in  1  JALR
- br_opcode_i  in  BR_OPCODE_WIDTH  funct3 compare select
- rs1_i, rs2_i  in  API_DATA_WIDTH  operands
- imm_i  in  API_DATA_WIDTH  sign-extended immediate
- redirect_valid_o  out  1  registered flush/redirect pulse
- redirect_pc_o  out  API_ADDR_WIDTH  registered redirect target
- link_pc_o  out  API_ADDR_WIDTH  res_pc_i+4; combinational, for rd write
- misaligned_o  out  1  registered pulse: taken target has bit1 set
- br_count_o  out  CNT_WIDTH  resolved control-flow count
- mispred_count_o  out  CNT_WIDTH  redirect count

Behaviour:
- Reset (async, rst_i=1):
  - all BHT counters = 2'b01 (weakly not-taken);
  - redirect_valid_o=0, redirect_pc_o=0, misaligned_o=0;
  - br_count_o=0, mispred_count_o=0;
  - state=RUN.
  - Reset mid-redirect drops the pulse immediately.
- BHT index = pc[log2(BHT_ENTRIES)+1:2]. fetch_pred_taken_o = counter[idx][1].
- Compare, by funct3:
  - BEQ 000: rs1==rs2
  - BNE 001: rs1!=rs2
  - BLT 100: signed <
  - BGE 101: signed >=
  - BLTU 110: unsigned <
  - BGEU 111: unsigned >=
  - undefined codes: not taken
- Actual direction: taken = conditional ? compare : (jal|jalr).
- Actual target:
  - branch/JAL: res_pc_i+imm_i;
  - JALR: (rs1_i+imm_i) with bit0 cleared.
  - All sums wrap modulo 2^API_ADDR_WIDTH.
- Mispredict (only on an accepted resolve):
  - conditional: taken != res_pred_taken_i;
  - JAL/JALR: always a mispredict (fetch does no target prediction).
  - Redirect PC = taken ? target : res_pc_i+4.
- Accept rule: a resolve is accepted when res_valid_i=1 and state=RUN.
- FSM, two states:
  - RUN: on accepted mispredict, latch the redirect next edge and go to SHADOW.
  - SHADOW: lasts exactly 1 cycle. res_valid_i is ignored (wrong-path instruction): no BHT update, no stats, no redirect. Then return to RUN.
- Latency: redirect_valid_o is high for exactly 1 cycle, on the edge after acceptance. redirect_pc_o holds its value until the next redirect.
- Misaligned taken target (target[1]=1, taken):
  - misaligned_o pulses instead of redirect_valid_o;
  - the FSM still enters SHADOW;
  - the BHT still updates.
- BHT update (accepted conditional only): taken ? sat-increment : sat-decrement. 2'b11 stays 11; 2'b00 stays 00. Unconditional jumps do not touch the BHT.
- Fetch lookup and update to the same index in the same cycle: the lookup returns the pre-update value (read-before-write).
- Statistics:
  - br_count_o increments on every accepted resolve;
  - mispred_count_o increments on redirect or misaligned;
  - both saturate at all-ones.
- Simultaneous res_jal_i/res_jalr_i/res_conditional_i: priority jalr > jal > conditional.

Decomposition:
- DEFINITIONS.v: BR_OPCODE_* funct3 values, BR_OPCODE_WIDTH=3, BHT_INIT=2'b01, state encodings BR_ST_RUN/BR_ST_SHADOW.
- Sub-module rv32im_br_bht: counter array, read port, saturating update port, async reset of all entries.
- Comparator, target adder, FSM and stats stay in the top.

Test Plan:
- Post-reset, fetch_pc_i=0x100 -> fetch_pred_taken_o=0. BEQ at 0x100, rs1=rs2=5, imm=0x20, pred=0 -> next cycle redirect_valid_o=1, redirect_pc_o=0x120; counter[0x40&mask] becomes 10.
- Same BEQ twice more with pred from BHT -> second is predicted taken, no redirect; counter saturates at 11 after further taken hits; br_count_o=3, mispred_count_o=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken. Pred=1 on BLTU at 0x200 -> redirect_pc_o=0x204.
- JALR rs1=0x1001, imm=4 -> redirect_pc_o=0x1004; link_pc_o=pc+4. The next cycle's res_valid_i=1 BNE is ignored (no stats change, no BHT change).
- Taken BEQ with imm=0x6 from 0x100 -> misaligned_o pulse, no redirect_valid_o, mispred_count_o+1.
- Assert rst_i asynchronously in the cycle redirect_valid_o=1 -> output drops without a clock edge; counters=0; BHT reads 0.

Source files
------------

// File: rtl/rv32im_br_unit_pkg.sv
// rv32im_br_unit_pkg
// Shared definitions for the branch resolution unit: funct3 compare
// selects, BHT counter reset value, FSM state encoding and the 2-bit
// saturating counter update helper.
// Ports: none (package).
package rv32im_br_unit_pkg;

  localparam int BR_OPCODE_WIDTH = 3;

  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BEQ  = 3'b000;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BNE  = 3'b001;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BLT  = 3'b100;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BGE  = 3'b101;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BLTU = 3'b110;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BGEU = 3'b111;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef enum logic {
    BR_ST_RUN    = 1'b0,
    BR_ST_SHADOW = 1'b1
  } br_state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/rv32im_br_unit_if.sv
// rv32im_br_unit_if
// Groups the fetch lookup, EX resolve and redirect/statistics signals of
// the branch unit. The master modport is the pipeline side, the slave
// modport is the branch unit.
// Signals: fetch_pc_i/fetch_pred_taken_o (BHT lookup), res_* and operand
// inputs (resolve), redirect_*/misaligned_o (registered pulses),
// link_pc_o (rd write value), br_count_o/mispred_count_o (statistics).
interface rv32im_br_unit_if
  import rv32im_br_unit_pkg::*;
#(
  parameter int API_ADDR_WIDTH = 32,
  parameter int API_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
);

  logic [API_ADDR_WIDTH-1:0]  fetch_pc_i;
  logic                       fetch_pred_taken_o;
  logic                       res_valid_i;
  logic [API_ADDR_WIDTH-1:0]  res_pc_i;
  logic                       res_pred_taken_i;
  logic                       res_conditional_i;
  logic                       res_jal_i;
  logic                       res_jalr_i;
  logic [BR_OPCODE_WIDTH-1:0] br_opcode_i;
  logic [API_DATA_WIDTH-1:0]  rs1_i;
  logic [API_DATA_WIDTH-1:0]  rs2_i;
  logic [API_DATA_WIDTH-1:0]  imm_i;
  logic                       redirect_valid_o;
  logic [API_ADDR_WIDTH-1:0]  redirect_pc_o;
  logic [API_ADDR_WIDTH-1:0]  link_pc_o;
  logic                       misaligned_o;
  logic [CNT_WIDTH-1:0]       br_count_o;
  logic [CNT_WIDTH-1:0]       mispred_count_o;

  modport master (
    output fetch_pc_i, res_valid_i, res_pc_i, res_pred_taken_i,
           res_conditional_i, res_jal_i, res_jalr_i, br_opcode_i,
           rs1_i, rs2_i, imm_i,
    input  fetch_pred_taken_o, redirect_valid_o, redirect_pc_o,
           link_pc_o, misaligned_o, br_count_o, mispred_count_o
  );

  modport slave (
    input  fetch_pc_i, res_valid_i, res_pc_i, res_pred_taken_i,
           res_conditional_i, res_jal_i, res_jalr_i, br_opcode_i,
           rs1_i, rs2_i, imm_i,
    output fetch_pred_taken_o, redirect_valid_o, redirect_pc_o,
           link_pc_o, misaligned_o, br_count_o, mispred_count_o
  );

endinterface

// File: rtl/rv32im_br_unit_bht.sv
// rv32im_br_bht
// Branch history table of 2-bit saturating counters.
// Ports: clk, rst (async active-high, all entries to weakly not-taken),
// rd_idx/rd_taken (combinational lookup, counter MSB),
// wr_en/wr_idx/wr_taken (saturating increment on taken, decrement otherwise).
// The read port sees the pre-update value when both ports hit one entry.
module rv32im_br_bht
  import rv32im_br_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr [ENTRIES];

  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_INIT;
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/rv32im_br_unit.sv
// rv32im_br_unit
// Resolves conditional branches, JAL and JALR in EX with its own operand
// comparator, trains the BHT used by fetch, issues a registered one-cycle
// redirect (or misaligned-target pulse) on mispredict and keeps saturating
// branch/mispredict statistics.
// Ports: clk_i, rst_i (async active-high), bus (slave side of
// rv32im_br_unit_if: fetch lookup, resolve inputs, redirect/link/stats).
module rv32im_br_unit
  import rv32im_br_unit_pkg::*;
#(
  parameter int API_ADDR_WIDTH = 32,
  parameter int API_DATA_WIDTH = 32,
  parameter int BHT_ENTRIES    = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rv32im_br_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  br_state_e state_q, state_d;

  logic                      cmp_taken;
  logic                      is_jalr, is_jal, is_cond;
  logic                      taken, mispredict, tgt_misaligned;
  logic [API_ADDR_WIDTH-1:0] pc_imm, jalr_sum, target, link_pc, new_pc;
  logic                      accept, redirect_fire, mis_fire, bht_we, stat_inc_br, stat_inc_mp;

  logic                      redirect_valid_q, misaligned_q;
  logic [API_ADDR_WIDTH-1:0] redirect_pc_q;
  logic [CNT_WIDTH-1:0]      br_count_q, mispred_count_q;

  // Comparator: undefined funct3 codes resolve as not taken.
  always_comb begin
    cmp_taken = 1'b0;
    case (bus.br_opcode_i)
      BR_OPCODE_BEQ:  cmp_taken = (bus.rs1_i == bus.rs2_i);
      BR_OPCODE_BNE:  cmp_taken = (bus.rs1_i != bus.rs2_i);
      BR_OPCODE_BLT:  cmp_taken = ($signed(bus.rs1_i) <  $signed(bus.rs2_i));
      BR_OPCODE_BGE:  cmp_taken = ($signed(bus.rs1_i) >= $signed(bus.rs2_i));
      BR_OPCODE_BLTU: cmp_taken = (bus.rs1_i <  bus.rs2_i);
      BR_OPCODE_BGEU: cmp_taken = (bus.rs1_i >= bus.rs2_i);
      default:        cmp_taken = 1'b0;
    endcase
  end

  // Kind decode with jalr > jal > conditional priority, so at most one is set.
  assign is_jalr = bus.res_jalr_i;
  assign is_jal  = bus.res_jal_i & ~bus.res_jalr_i;
  assign is_cond = bus.res_conditional_i & ~bus.res_jal_i & ~bus.res_jalr_i;

  assign pc_imm   = bus.res_pc_i + API_ADDR_WIDTH'(bus.imm_i);
  assign jalr_sum = API_ADDR_WIDTH'(bus.rs1_i + bus.imm_i);
  assign target   = is_jalr ? {jalr_sum[API_ADDR_WIDTH-1:1], 1'b0} : pc_imm;
  assign link_pc  = bus.res_pc_i + API_ADDR_WIDTH'(4);

  // Fetch never predicts jump targets, so every jump costs a redirect.
  assign taken          = is_jalr | is_jal | (is_cond & cmp_taken);
  assign mispredict     = is_jalr | is_jal | (is_cond & (cmp_taken != bus.res_pred_taken_i));
  assign tgt_misaligned = taken & target[1];
  assign new_pc         = taken ? target : link_pc;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= BR_ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: the shadow covers the single wrong-path slot after a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_ST_RUN:    if (accept && (mispredict || tgt_misaligned)) state_d = BR_ST_SHADOW;
      BR_ST_SHADOW: state_d = BR_ST_RUN;
      default:      state_d = BR_ST_RUN;
    endcase
  end

  // Output decode: a misaligned taken target replaces the redirect pulse.
  always_comb begin
    accept        = bus.res_valid_i & (state_q == BR_ST_RUN);
    redirect_fire = accept & mispredict & ~tgt_misaligned;
    mis_fire      = accept & tgt_misaligned;
    bht_we        = accept & is_cond;
    stat_inc_br   = accept;
    stat_inc_mp   = redirect_fire | mis_fire;
  end

  // Registered pulses; redirect_pc holds until the next real redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_valid_q <= 1'b0;
      misaligned_q     <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_fire;
      misaligned_q     <= mis_fire;
      if (redirect_fire) redirect_pc_q <= new_pc;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (stat_inc_br && br_count_q != '1) br_count_q <= br_count_q + CNT_WIDTH'(1);
      if (stat_inc_mp && mispred_count_q != '1) mispred_count_q <= mispred_count_q + CNT_WIDTH'(1);
    end
  end

  rv32im_br_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_idx   (bus.fetch_pc_i[IDX_W+1:2]),
    .rd_taken (bus.fetch_pred_taken_o),
    .wr_en    (bht_we),
    .wr_idx   (bus.res_pc_i[IDX_W+1:2]),
    .wr_taken (cmp_taken)
  );

  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.misaligned_o     = misaligned_q;
  assign bus.link_pc_o        = link_pc;
  assign bus.br_count_o       = br_count_q;
  assign bus.mispred_count_o  = mispred_count_q;

endmodule

// File: tb/tb_rv32im_br_unit.sv
// tb_rv32im_br_unit
// Directed and randomized stimulus for rv32im_br_unit, checked against a
// behavioural model: BHT as an array of integer counters, statistics as
// integers, and a flag for the wrong-path slot after a flush.
module tb_rv32im_br_unit;
  import rv32im_br_unit_pkg::*;

  localparam int BHT = 64;

  logic clk;
  logic rst;

  rv32im_br_unit_if #(.API_ADDR_WIDTH(32), .API_DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

  rv32im_br_unit #(
    .API_ADDR_WIDTH (32),
    .API_DATA_WIDTH (32),
    .BHT_ENTRIES    (BHT),
    .CNT_WIDTH      (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests;
  int          failures;
  int          bht [BHT];
  bit          shadow;
  int          br_cnt;
  int          mp_cnt;
  logic [31:0] exp_rpc;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < BHT; i++) bht[i] = 1;
    shadow  = 1'b0;
    br_cnt  = 0;
    mp_cnt  = 0;
    exp_rpc = 32'h0;
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks the
  // combinational outputs mid-cycle and the registered ones after the edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic pred,
                                input logic c, input logic j, input logic jr,
                                input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] fpc);
    logic        cmp, tk, mp, mis, exp_rv, exp_mis, nshadow;
    logic [31:0] tgt;
    bus.res_valid_i       = v;
    bus.res_pc_i          = pc;
    bus.res_pred_taken_i  = pred;
    bus.res_conditional_i = c;
    bus.res_jal_i         = j;
    bus.res_jalr_i        = jr;
    bus.br_opcode_i       = op;
    bus.rs1_i             = a;
    bus.rs2_i             = b;
    bus.imm_i             = imm;
    bus.fetch_pc_i        = fpc;
    #4;
    check_output("fetch_pred", 32'(bus.fetch_pred_taken_o), 32'(bht[fpc[7:2]] >= 2));
    check_output("link_pc", bus.link_pc_o, pc + 32'd4);

    exp_rv = 1'b0; exp_mis = 1'b0; nshadow = 1'b0;
    if (v && !shadow) begin
      if (br_cnt < 65535) br_cnt++;
      case (op)
        3'b000:  cmp = (a == b);
        3'b001:  cmp = (a != b);
        3'b100:  cmp = ($signed(a) < $signed(b));
        3'b101:  cmp = !($signed(a) < $signed(b));
        3'b110:  cmp = (a < b);
        3'b111:  cmp = !(a < b);
        default: cmp = 1'b0;
      endcase
      if (jr) begin
        tk = 1'b1; mp = 1'b1; tgt = (a + imm) & 32'hFFFF_FFFE;
      end else if (j) begin
        tk = 1'b1; mp = 1'b1; tgt = pc + imm;
      end else if (c) begin
        tk = cmp; mp = (cmp != pred); tgt = pc + imm;
        if (cmp && bht[pc[7:2]] < 3) bht[pc[7:2]]++;
        if (!cmp && bht[pc[7:2]] > 0) bht[pc[7:2]]--;
      end else begin
        tk = 1'b0; mp = 1'b0; tgt = pc + imm;
      end
      mis = tk && tgt[1];
      if (mis) exp_mis = 1'b1;
      else if (mp) begin
        exp_rv  = 1'b1;
        exp_rpc = tk ? tgt : pc + 32'd4;
      end
      if (mis || mp) begin
        nshadow = 1'b1;
        if (mp_cnt < 65535) mp_cnt++;
      end
    end
    shadow = nshadow;

    @(posedge clk);
    #1;
    check_output("redirect_valid", 32'(bus.redirect_valid_o), 32'(exp_rv));
    check_output("misaligned", 32'(bus.misaligned_o), 32'(exp_mis));
    check_output("redirect_pc", bus.redirect_pc_o, exp_rpc);
    check_output("br_count", 32'(bus.br_count_o), 32'(br_cnt));
    check_output("mispred_count", 32'(bus.mispred_count_o), 32'(mp_cnt));
  endtask

  task automatic idle_step(input logic [31:0] fpc);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, fpc);
  endtask

  initial begin
    logic [31:0] r_pc, r_a, r_b, r_imm, r_fpc;
    logic [2:0]  r_op;
    logic        r_v, r_c, r_j, r_jr, r_pred;
    int          kind;

    tests    = 0;
    failures = 0;
    model_reset();
    rst = 1'b1;
    bus.res_valid_i = 1'b0; bus.res_pc_i = 32'h0; bus.res_pred_taken_i = 1'b0;
    bus.res_conditional_i = 1'b0; bus.res_jal_i = 1'b0; bus.res_jalr_i = 1'b0;
    bus.br_opcode_i = 3'b000; bus.rs1_i = 32'h0; bus.rs2_i = 32'h0;
    bus.imm_i = 32'h0; bus.fetch_pc_i = 32'h100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_output("rst_redirect_valid", 32'(bus.redirect_valid_o), 32'h0);
    check_output("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
    check_output("rst_misaligned", 32'(bus.misaligned_o), 32'h0);
    check_output("rst_br_count", 32'(bus.br_count_o), 32'h0);
    check_output("rst_fetch_pred", 32'(bus.fetch_pred_taken_o), 32'h0);

    // BEQ at 0x100 predicted not-taken but taken: redirect to 0x120
    apply_stimulus(1, 32'h100, 0, 1, 0, 0, BR_OPCODE_BEQ, 5, 5, 32'h20, 32'h100);
    check_output("beq_redirect_pc", bus.redirect_pc_o, 32'h120);
    // Shadow slot: BNE ignored; BHT entry now reads weakly taken
    apply_stimulus(1, 32'h100, 0, 1, 0, 0, BR_OPCODE_BNE, 1, 2, 32'h40, 32'h100);
    apply_stimulus(1, 32'h100, 1, 1, 0, 0, BR_OPCODE_BEQ, 5, 5, 32'h20, 32'h100);
    apply_stimulus(1, 32'h100, 1, 1, 0, 0, BR_OPCODE_BEQ, 5, 5, 32'h20, 32'h100);
    check_output("beq3_br_count", 32'(bus.br_count_o), 32'd3);
    check_output("beq3_mispred_count", 32'(bus.mispred_count_o), 32'd1);
    apply_stimulus(1, 32'h100, 1, 1, 0, 0, BR_OPCODE_BEQ, 5, 5, 32'h20, 32'h100);

    // Signed vs unsigned compare on the same operands
    apply_stimulus(1, 32'h200, 1, 1, 0, 0, BR_OPCODE_BLT, 32'hFFFF_FFFF, 1, 32'h40, 32'h200);
    check_output("blt_no_redirect", 32'(bus.redirect_valid_o), 32'h0);
    apply_stimulus(1, 32'h200, 1, 1, 0, 0, BR_OPCODE_BLTU, 32'hFFFF_FFFF, 1, 32'h40, 32'h200);
    check_output("bltu_redirect_pc", bus.redirect_pc_o, 32'h204);
    idle_step(32'h200);

    // JALR clears bit0 of the target; following BNE is wrong-path
    apply_stimulus(1, 32'h300, 0, 0, 0, 1, BR_OPCODE_BEQ, 32'h1001, 0, 32'h4, 32'h300);
    check_output("jalr_redirect_pc", bus.redirect_pc_o, 32'h1004);
    apply_stimulus(1, 32'h300, 0, 1, 0, 0, BR_OPCODE_BNE, 1, 2, 32'h8, 32'h300);

    // Misaligned taken target
    apply_stimulus(1, 32'h100, 0, 1, 0, 0, BR_OPCODE_BEQ, 7, 7, 32'h6, 32'h100);
    check_output("mis_pulse", 32'(bus.misaligned_o), 32'h1);
    idle_step(32'h100);

    // JAL+conditional together: treated as JAL, BHT untouched
    apply_stimulus(1, 32'h140, 1, 1, 1, 0, BR_OPCODE_BNE, 3, 3, 32'h10, 32'h140);
    idle_step(32'h140);

    // Async reset while the redirect pulse is high
    apply_stimulus(1, 32'h180, 0, 0, 1, 0, BR_OPCODE_BEQ, 0, 0, 32'h40, 32'h100);
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_redirect", 32'(bus.redirect_valid_o), 32'h0);
    check_output("async_rst_br_count", 32'(bus.br_count_o), 32'h0);
    check_output("async_rst_mp_count", 32'(bus.mispred_count_o), 32'h0);
    check_output("async_rst_bht", 32'(bus.fetch_pred_taken_o), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r_v    = ($urandom_range(0, 4) != 0);
      r_pc   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      r_pred = 1'($urandom_range(0, 1));
      kind   = $urandom_range(0, 5);
      r_c = (kind <= 2); r_j = (kind == 3); r_jr = (kind == 4);
      if (kind == 5) begin
        r_c = 1'($urandom_range(0, 1)); r_j = 1'($urandom_range(0, 1)); r_jr = 1'($urandom_range(0, 1));
      end
      r_op  = 3'($urandom_range(0, 7));
      r_a   = $urandom;
      if ($urandom_range(0, 2) == 0) r_a = 32'($urandom_range(0, 3)) - 32'd2;
      r_b   = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
      if ($urandom_range(0, 2) == 0) r_b = 32'($urandom_range(0, 3)) - 32'd2;
      r_imm = (32'($urandom_range(0, 1023)) & 32'h3FE) - 32'h200;
      if (r_jr) r_imm = r_imm | 32'($urandom_range(0, 1));
      r_fpc = ($urandom_range(0, 2) == 0) ? r_pc : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      apply_stimulus(r_v, r_pc, r_pred, r_c, r_j, r_jr, r_op, r_a, r_b, r_imm, r_fpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
